// File: rtl/json_cmd_pkg.sv
// Shared definitions for the JSON motor-command parser: FSM states, number
// accumulator phases, ASCII byte constants and the speed field width.
package json_cmd_pkg;

    localparam int SPEED_W = 11;

    localparam logic [7:0] CH_LBRACE = 8'h7B;  // '{'
    localparam logic [7:0] CH_RBRACE = 8'h7D;  // '}'
    localparam logic [7:0] CH_QUOTE  = 8'h22;  // '"'
    localparam logic [7:0] CH_COLON  = 8'h3A;  // ':'
    localparam logic [7:0] CH_COMMA  = 8'h2C;  // ','
    localparam logic [7:0] CH_MINUS  = 8'h2D;  // '-'
    localparam logic [7:0] CH_DOT    = 8'h2E;  // '.'
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_T      = 8'h54;  // 'T'
    localparam logic [7:0] CH_L      = 8'h4C;  // 'L'
    localparam logic [7:0] CH_R      = 8'h52;  // 'R'

    typedef enum logic [2:0] {
        IDLE, KEY_OPEN, KEY_NAME, KEY_CLOSE, COLON, VALUE, SEP, EOL
    } parse_state_t;

    // Progress through one numeric token.
    typedef enum logic [2:0] {
        NUM_START, NUM_SIGN, NUM_INT, NUM_DOT, NUM_F1, NUM_F2
    } num_phase_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Key letter expected for field 0 (T), 1 (L), 2 (R).
    function automatic logic [7:0] key_char(input logic [1:0] field);
        case (field)
            2'd0:    return CH_T;
            2'd1:    return CH_L;
            default: return CH_R;
        endcase
    endfunction

endpackage

// File: rtl/json_num_accum.sv
// Numeric token accumulator. Integer mode: 1-3 digits, 0..255. Speed mode:
// optional '-', one integer digit, optional '.' plus 1-2 fraction digits,
// accumulated directly in hundredths. num_err flags that the byte on ch
// would be illegal in the current phase (syntax or range); complete means
// the token seen so far may legally be terminated.
module json_num_accum
    import json_cmd_pkg::*;
(
    input  logic               clk_50,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               stb,
    input  logic               speed_mode,
    input  logic [7:0]         ch,
    output logic [SPEED_W-1:0] value,
    output logic               num_err,
    output logic               complete
);

    num_phase_t         phase_q, phase_d;
    logic [SPEED_W-1:0] mag_q, mag_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [15:0]        int_next;
    logic [SPEED_W-1:0] dig;

    assign dig      = {7'b0, ch[3:0]};
    assign int_next = {5'b0, mag_q} * 16'd10 + {12'b0, ch[3:0]};
    assign complete = (phase_q == NUM_INT) || (phase_q == NUM_F1) || (phase_q == NUM_F2);
    assign value    = neg_q ? (~mag_q + 11'd1) : mag_q;

    // Judge the incoming byte and compute the next accumulator state.
    always_comb begin
        phase_d = phase_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        num_err = 1'b0;
        if (clr) begin
            phase_d = NUM_START;
            mag_d   = '0;
            cnt_d   = '0;
            neg_d   = 1'b0;
        end else if (!speed_mode) begin
            if (!is_digit(ch) || (cnt_q == 2'd3) || (int_next > 16'd255)) begin
                num_err = 1'b1;
            end else if (stb) begin
                mag_d   = int_next[SPEED_W-1:0];
                cnt_d   = cnt_q + 2'd1;
                phase_d = NUM_INT;
            end
        end else begin
            case (phase_q)
                NUM_START: begin
                    if (ch == CH_MINUS) begin
                        if (stb) begin
                            neg_d   = 1'b1;
                            phase_d = NUM_SIGN;
                        end
                    end else if (is_digit(ch)) begin
                        if (stb) begin
                            mag_d   = dig * 11'd100;
                            phase_d = NUM_INT;
                        end
                    end else begin
                        num_err = 1'b1;
                    end
                end
                NUM_SIGN: begin
                    if (is_digit(ch)) begin
                        if (stb) begin
                            mag_d   = dig * 11'd100;
                            phase_d = NUM_INT;
                        end
                    end else begin
                        num_err = 1'b1;
                    end
                end
                NUM_INT: begin
                    // A second integer digit is illegal; only '.' may follow.
                    if (ch == CH_DOT) begin
                        if (stb) phase_d = NUM_DOT;
                    end else begin
                        num_err = 1'b1;
                    end
                end
                NUM_DOT: begin
                    if (is_digit(ch)) begin
                        if (stb) begin
                            mag_d   = mag_q + dig * 11'd10;
                            phase_d = NUM_F1;
                        end
                    end else begin
                        num_err = 1'b1;
                    end
                end
                NUM_F1: begin
                    if (is_digit(ch)) begin
                        if (stb) begin
                            mag_d   = mag_q + dig;
                            phase_d = NUM_F2;
                        end
                    end else begin
                        num_err = 1'b1;
                    end
                end
                default: num_err = 1'b1;
            endcase
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= NUM_START;
            mag_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: rtl/json_cmd_parser.sv
// Byte-serial parser for frames {"T":<t>,"L":<s>,"R":<s>}[\r]\n.
// Fields are staged while the frame arrives and published together with a
// cmd_valid pulse once the line feed is accepted. Any unexpected byte pulses
// parse_error and abandons the frame; a '{' restarts a new frame at once.
// Optional feature: define JSON_CMD_TIMEOUT_EN to force both speeds to zero
// after TIMEOUT_CYCLES clocks without a valid command.
module json_cmd_parser
    import json_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15_000_000
) (
    input  logic               clk_50,
    input  logic               reset_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               cmd_valid,
    output logic [7:0]         cmd_type,
    output logic [SPEED_W-1:0] left_speed,
    output logic [SPEED_W-1:0] right_speed,
    output logic               parse_error,
    output logic [7:0]         error_count,
    output logic               cmd_timeout
);

    parse_state_t       state_q, state_d;
    logic [1:0]         field_q, field_d;
    logic [7:0]         t_hold_q, t_hold_d;
    logic [SPEED_W-1:0] l_hold_q, l_hold_d;
    logic [SPEED_W-1:0] r_hold_q, r_hold_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [7:0]         cmd_type_q, cmd_type_d;
    logic [SPEED_W-1:0] left_q, left_d;
    logic [SPEED_W-1:0] right_q, right_d;
    logic               parse_error_q, parse_error_d;
    logic [7:0]         error_count_q, error_count_d;
`ifdef JSON_CMD_TIMEOUT_EN
    logic               cmd_timeout_q, cmd_timeout_d;
    logic [31:0]        tmo_cnt_q, tmo_cnt_d;
`endif

    logic               acc_clr, acc_stb, acc_err, acc_done, bad;
    logic [SPEED_W-1:0] acc_value;

    json_num_accum u_accum (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .clr        (acc_clr),
        .stb        (acc_stb),
        .speed_mode (field_q != 2'd0),
        .ch         (rx_data),
        .value      (acc_value),
        .num_err    (acc_err),
        .complete   (acc_done)
    );

    // Frame FSM: advance on each accepted byte, stage fields, publish on LF.
    always_comb begin
        state_d       = state_q;
        field_d       = field_q;
        t_hold_d      = t_hold_q;
        l_hold_d      = l_hold_q;
        r_hold_d      = r_hold_q;
        cmd_valid_d   = 1'b0;
        cmd_type_d    = cmd_type_q;
        left_d        = left_q;
        right_d       = right_q;
        parse_error_d = 1'b0;
        error_count_d = error_count_q;
        acc_clr       = 1'b0;
        acc_stb       = 1'b0;
        bad           = 1'b0;
        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == CH_LBRACE) begin
                        state_d = KEY_OPEN;
                        field_d = 2'd0;
                    end
                end
                KEY_OPEN: begin
                    if (rx_data == CH_QUOTE) state_d = KEY_NAME;
                    else                     bad     = 1'b1;
                end
                KEY_NAME: begin
                    if (rx_data == key_char(field_q)) state_d = KEY_CLOSE;
                    else                              bad     = 1'b1;
                end
                KEY_CLOSE: begin
                    if (rx_data == CH_QUOTE) state_d = COLON;
                    else                     bad     = 1'b1;
                end
                COLON: begin
                    if (rx_data == CH_COLON) begin
                        state_d = VALUE;
                        acc_clr = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                VALUE: begin
                    if ((rx_data == CH_COMMA) && (field_q != 2'd2)) begin
                        if (acc_done) begin
                            if (field_q == 2'd0) t_hold_d = acc_value[7:0];
                            else                 l_hold_d = acc_value;
                            field_d = field_q + 2'd1;
                            state_d = KEY_OPEN;
                        end else begin
                            bad = 1'b1;
                        end
                    end else if ((rx_data == CH_RBRACE) && (field_q == 2'd2)) begin
                        if (acc_done) begin
                            r_hold_d = acc_value;
                            state_d  = SEP;
                        end else begin
                            bad = 1'b1;
                        end
                    end else if (acc_err) begin
                        bad = 1'b1;
                    end else begin
                        acc_stb = 1'b1;
                    end
                end
                SEP, EOL: begin
                    // A single CR is tolerated only right after the brace.
                    if ((rx_data == CH_CR) && (state_q == SEP)) begin
                        state_d = EOL;
                    end else if (rx_data == CH_LF) begin
                        state_d     = IDLE;
                        cmd_valid_d = 1'b1;
                        cmd_type_d  = t_hold_q;
                        left_d      = l_hold_q;
                        right_d     = r_hold_q;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: bad = 1'b1;
            endcase

            if (bad) begin
                parse_error_d = 1'b1;
                field_d       = 2'd0;
                state_d       = (rx_data == CH_LBRACE) ? KEY_OPEN : IDLE;
                if (error_count_q != 8'hFF) error_count_d = error_count_q + 8'd1;
            end
        end

`ifdef JSON_CMD_TIMEOUT_EN
        // Watchdog: a fresh command restarts it, expiry zeroes both speeds.
        cmd_timeout_d = cmd_timeout_q;
        tmo_cnt_d     = tmo_cnt_q;
        if (cmd_valid_d) begin
            cmd_timeout_d = 1'b0;
            tmo_cnt_d     = '0;
        end else if (!cmd_timeout_q) begin
            if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                cmd_timeout_d = 1'b1;
                left_d        = '0;
                right_d       = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            field_q       <= '0;
            t_hold_q      <= '0;
            l_hold_q      <= '0;
            r_hold_q      <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_type_q    <= '0;
            left_q        <= '0;
            right_q       <= '0;
            parse_error_q <= 1'b0;
            error_count_q <= '0;
`ifdef JSON_CMD_TIMEOUT_EN
            cmd_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            field_q       <= field_d;
            t_hold_q      <= t_hold_d;
            l_hold_q      <= l_hold_d;
            r_hold_q      <= r_hold_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_type_q    <= cmd_type_d;
            left_q        <= left_d;
            right_q       <= right_d;
            parse_error_q <= parse_error_d;
            error_count_q <= error_count_d;
`ifdef JSON_CMD_TIMEOUT_EN
            cmd_timeout_q <= cmd_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_type    = cmd_type_q;
    assign left_speed  = left_q;
    assign right_speed = right_q;
    assign parse_error = parse_error_q;
    assign error_count = error_count_q;
`ifdef JSON_CMD_TIMEOUT_EN
    assign cmd_timeout = cmd_timeout_q;
`else
    assign cmd_timeout = 1'b0;
`endif

endmodule

// File: doc/json_cmd_parser.md
JSON_CMD_PARSER -- requirements
Module: json_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15_000_000, meaning clk_50 cycles without a valid command before forced stop (used only with CMD_TIMEOUT_EN).
REQ-002 SHALL have port clk_50  input  1  sole clock, all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port cmd_valid  output  1  one-cycle pulse on complete, well-formed command.
REQ-007 SHALL have port cmd_type  output  8  value of "T" field, unsigned.
REQ-008 SHALL have port left_speed  output  11  "L" field in signed hundredths (two's complement).
REQ-009 SHALL have port right_speed  output  11  "R" field in signed hundredths.
REQ-010 SHALL have port parse_error  output  1  one-cycle pulse on malformed frame.
REQ-011 SHALL have port error_count  output  8  saturating count of parse_error pulses.
REQ-012 SHALL have port cmd_timeout  output  1  level, high while stop is forced by timeout (tied 0 without CMD_TIMEOUT_EN).

Function
REQ-013 SHALL accept exactly the frame {"T":<t>,"L":<s>,"R":<s>}\n: keys in order T, L, R, no whitespace, a single optional 0x0D before 0x0A.
REQ-014 SHALL process one byte per rx_valid cycle and ignore rx_data when rx_valid=0.
REQ-015 SHALL use FSM states IDLE, KEY_OPEN, KEY_NAME, KEY_CLOSE, COLON, VALUE, SEP, EOL; IDLE waits for '{'; any other byte in IDLE is silently dropped, with no error.
REQ-016 SHALL parse <t> as 1-3 decimal digits with value 0-255; sign, '.', a value above 255, or a 4th digit SHALL be an error.
REQ-017 SHALL parse <s> as an optional '-', exactly one integer digit, then optionally '.' followed by 1-2 fraction digits, scaled to hundredths ("0.05"->5, "-0.5"->-50, "1"->100, "-0"->0).
REQ-018 SHALL treat as errors: a missing integer digit, '.' with no fraction digit, a 3rd fraction digit, or a 2nd integer digit.
REQ-019 SHALL compute value = int*100 + frac_d1*10 + frac_d2 in 11 bits, then negate if '-'; range -999..999, no overflow possible.
REQ-020 SHALL latch cmd_type, left_speed and right_speed together and pulse cmd_valid in the cycle after the 0x0A byte is accepted; outputs hold until the next valid frame.
REQ-021 SHALL, on any unexpected byte, pulse parse_error the next cycle, leave output fields unchanged, and go to IDLE.
REQ-022 SHALL, when the offending byte of REQ-021 is '{', go to KEY_OPEN instead of IDLE (resynchronisation).
REQ-023 SHALL treat '{' received in any non-IDLE state as an error followed by resync (REQ-022).
REQ-024 SHALL increment error_count on each parse_error pulse, saturating at 255.

Reset
REQ-025 SHALL, while reset_n=0, force the FSM to IDLE and all outputs to 0 (cmd_valid, cmd_type, left_speed, right_speed, parse_error, error_count, cmd_timeout, timeout counter).
REQ-026 SHALL discard any partial frame when reset is asserted mid-frame; the first byte after reset is interpreted in IDLE.

Configuration
REQ-027 SHALL, with macro JSON_CMD_TIMEOUT_EN defined, count cycles since the last cmd_valid; on reaching TIMEOUT_CYCLES it SHALL set left_speed=right_speed=0, hold cmd_type, assert cmd_timeout, and not pulse cmd_valid.
REQ-028 SHALL, with JSON_CMD_TIMEOUT_EN defined, clear cmd_timeout and restart the counter on the next cmd_valid.
REQ-029 SHALL, without JSON_CMD_TIMEOUT_EN, contain no timeout counter, hold speeds indefinitely, and tie cmd_timeout to 0.

Structure
REQ-030 SHALL place in package json_cmd_pkg: the FSM state enum, ASCII constants ('{', '}', '"', ':', ',', '-', '.', 0x0D, 0x0A), and SPEED_W=11.
REQ-031 SHALL implement digit accumulation, sign and fraction scaling in sub-module json_num_accum (clear, digit strobe, mode int/speed, value out, range-error flag).

Verification
REQ-032 SHALL cover: bytes {"T":1,"L":-0.05,"R":0.05}\n -> one cmd_valid; cmd_type=1, left_speed=-5, right_speed=5.
REQ-033 SHALL cover: {"T":1,"L":0.0,"R":0.0}\r\n -> cmd_valid; left_speed=0, right_speed=0.
REQ-034 SHALL cover: {"T":1,"L":0.123,"R":0}\n then {"T":2,"L":1,"R":-0.5}\n -> one parse_error, error_count=1, then cmd_valid with cmd_type=2, left_speed=100, right_speed=-50.
REQ-035 SHALL cover: {"T":1,"L {"T":3,"L":0.08,"R":-0.08}\n -> parse_error on the 2nd '{', then cmd_valid with cmd_type=3, left_speed=8, right_speed=-8.
REQ-036 SHALL cover: {"T":256,... -> parse_error; reset_n pulsed mid-frame -> all outputs 0 and the next full frame decodes correctly.
REQ-037 SHALL cover, with JSON_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: a valid frame L=0.05, then idle 100 cycles -> cmd_timeout=1, left_speed=0; the next frame clears cmd_timeout.
